// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants, types and the saturating subtract used by
//                the weight-bank update stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int P     = 64;              // neurons in the feeding layer
  localparam int FO    = 8;               // fan-out per neuron
  localparam int Z     = 32;              // banks / parallel weights per cycle
  localparam int EC    = 2;               // lag of w_addr behind r_addr (>= 1)
  localparam int WIDTH = 16;              // signed fixed-point weight width

  localparam int D   = P * FO / Z;        // words per bank
  localparam int AW  = (D > 1) ? $clog2(D) : 1;
  localparam int CPC = D + EC;            // clocks per block cycle
  localparam int CIW = (CPC > 1) ? $clog2(CPC) : 1;

  localparam logic [CIW-1:0] D_CI      = CIW'(D);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(D - 1);

  typedef logic signed [WIDTH-1:0] weight_t;
  typedef logic [AW-1:0]           addr_t;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // a - b computed one bit wider, then clamped to the weight range
  function automatic weight_t sat_sub(weight_t a, weight_t b);
    logic signed [WIDTH:0] diff;
    diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      sat_sub = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_sub = diff[WIDTH-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_update_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_update_mem_if
//  Description : Bus between the memory controller (master) and the weight
//                bank update stage (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_update_mem_if;
  import wb_pkg::*;

  logic [CIW-1:0]          cycle_index;
  logic [Z-1:0]            weA;
  logic [Z-1:0][AW-1:0]    r_addr;
  logic [Z-1:0][AW-1:0]    w_addr;
  logic [Z-1:0][WIDTH-1:0] delta;
  logic [Z-1:0][WIDTH-1:0] w_rd;
  logic                    w_rd_valid;
  logic                    ready;

  modport master (
    output cycle_index, weA, r_addr, w_addr, delta,
    input  w_rd, w_rd_valid, ready
  );

  modport slave (
    input  cycle_index, weA, r_addr, w_addr, delta,
    output w_rd, w_rd_valid, ready
  );

endinterface
`default_nettype wire

// File: rtl/wb_bank.sv
`default_nettype none
// ============================================================================
//  Module      : wb_bank
//  Description : One weight memory: registered read with write-first bypass,
//                clear port and saturating old-minus-delta write.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_bank
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr_en,
  input  addr_t   clr_addr,
  input  logic    rd_en,
  input  addr_t   r_addr,
  input  logic    we,
  input  addr_t   w_addr,
  input  weight_t old_w,
  input  weight_t delta,
  output weight_t rd_data
);

  weight_t mem [D];

  logic    wr_en;
  addr_t   wr_addr;
  weight_t wr_data;
  weight_t rd_d;
  weight_t rd_q;

  // Select between the clear sweep and a normal saturating update
  always_comb begin
    wr_en   = clr_en | we;
    wr_addr = clr_en ? clr_addr : w_addr;
    wr_data = clr_en ? '0 : sat_sub(old_w, delta);
  end

  // Read data; a same-cycle write to the read address wins
  always_comb begin
    rd_d = '0;
    if (rd_en) begin
      rd_d = (wr_en && (wr_addr == r_addr)) ? wr_data : mem[r_addr];
    end
  end

  // Storage array, no reset: contents are rebuilt by the clear sweep
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read output
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule
`default_nettype wire

// File: rtl/wb_update_mem.sv
`default_nettype none
// ============================================================================
//  Module      : wb_update_mem
//  Description : Weight-bank storage and update stage. Z banks served in
//                parallel; after reset a clear sweep zeroes every bank, then
//                reads/updates run until the next reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_update_mem
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  wb_update_mem_if.slave   bus
);

  state_t state_q;
  addr_t  clr_cnt_q;
  logic   ready_q;
  logic   valid_d;
  logic   valid_q;
  logic   is_clear;
  logic   is_run;

  // Clear sweep over all addresses, then stay in RUN until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + addr_t'(1);
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign is_clear = (state_q == ST_CLEAR);
  assign is_run   = (state_q == ST_RUN);

  // Read data is valid only for the D read slots of a block cycle
  always_comb begin
    valid_d = is_run && (bus.cycle_index < D_CI);
  end

  // Valid flag, aligned with the one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.w_rd_valid = valid_q;

  for (genvar i = 0; i < Z; i++) begin : g_bank
    weight_t rd_data;
    weight_t old_w;

    wb_bank u_bank (
      .clk      (clk),
      .reset    (reset),
      .clr_en   (is_clear),
      .clr_addr (clr_cnt_q),
      .rd_en    (is_run),
      .r_addr   (bus.r_addr[i]),
      .we       (is_run & bus.weA[i]),
      .w_addr   (bus.w_addr[i]),
      .old_w    (old_w),
      .delta    (bus.delta[i]),
      .rd_data  (rd_data)
    );

    assign bus.w_rd[i] = rd_data;

    // The read register is the first stage; EC-1 more give the old value
    if (EC == 1) begin : g_no_dly
      assign old_w = rd_data;
    end else begin : g_dly
      weight_t dly_d [EC-1];
      weight_t dly_q [EC-1];

      // Shift the read data one stage per cycle
      always_comb begin
        dly_d[0] = rd_data;
        for (int k = 1; k < EC - 1; k++) begin
          dly_d[k] = dly_q[k-1];
        end
      end

      // Pipeline registers, cleared on reset
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < EC - 1; k++) begin
            dly_q[k] <= '0;
          end
        end else begin
          dly_q <= dly_d;
        end
      end

      assign old_w = dly_q[EC-2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_update_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_update_mem
//  Description : Self-checking bench for wb_update_mem with a queue/array
//                reference model, table vectors and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_update_mem;
  import wb_pkg::*;

  typedef logic [Z-1:0][WIDTH-1:0] vec_t;

  typedef struct {
    int bank;
    int addr;
    int dlt;
    int exp;
  } vec_rec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wb_update_mem_if bus ();

  wb_update_mem dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;

  // Reference model: plain integer weights plus a queue of past read results
  int   mem_m [Z][D];
  vec_t hist [$];
  int   clr_left;
  bit   run_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mem_m[i, j]) mem_m[i][j] = 0;
    hist.delete();
    for (int k = 0; k < EC; k++) hist.push_back('0);
    clr_left = D;
    run_m    = 1'b0;
  endtask

  task automatic set_idle();
    bus.cycle_index = '0;
    bus.weA         = '0;
    bus.r_addr      = '0;
    bus.w_addr      = '0;
    bus.delta       = '0;
  endtask

  // One clock: advance the model on the current inputs, clock, then compare
  task automatic step();
    vec_t old_v;
    vec_t rd_now;
    bit   valid_e;
    rd_now  = '0;
    valid_e = 1'b0;
    if (reset) begin
      model_reset();
    end else if (!run_m) begin
      clr_left--;
      if (clr_left == 0) run_m = 1'b1;
      void'(hist.pop_front());
      hist.push_back('0);
    end else begin
      old_v = hist[0];
      for (int i = 0; i < Z; i++) begin
        if (bus.weA[i]) begin
          int d;
          d = int'($signed(old_v[i])) - int'($signed(bus.delta[i]));
          if (d >  32767) d =  32767;
          if (d < -32768) d = -32768;
          mem_m[i][bus.w_addr[i]] = d;
        end
      end
      for (int i = 0; i < Z; i++) begin
        int v;
        v = mem_m[i][bus.r_addr[i]];
        rd_now[i] = v[WIDTH-1:0];
      end
      valid_e = (int'(bus.cycle_index) < D);
      void'(hist.pop_front());
      hist.push_back(rd_now);
    end
    @(posedge clk);
    @(negedge clk);
    chk_vec("w_rd", bus.w_rd, hist[EC-1]);
    chk("w_rd_valid", int'(bus.w_rd_valid), int'(valid_e));
    chk("ready", int'(bus.ready), int'(run_m));
  endtask

  // Count clocks from reset release until ready rises (bounded)
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.ready && n < 4 * D) begin
      step();
      n++;
    end
    chk(name, n, D);
  endtask

  // One block cycle: reads sweep 0..D-1, writes trail by EC
  task automatic run_block(input logic [Z-1:0] mask, input int dlt);
    for (int c = 0; c < CPC; c++) begin
      set_idle();
      bus.cycle_index = CIW'(c);
      for (int i = 0; i < Z; i++) begin
        bus.r_addr[i] = (c < D) ? AW'(c) : '0;
        if (c >= EC) begin
          bus.w_addr[i] = AW'(c - EC);
          bus.delta[i]  = WIDTH'(dlt);
        end
      end
      if (c >= EC) bus.weA = mask;
      step();
    end
    set_idle();
  endtask

  // Read-then-update one word of one bank, return the read-back value
  task automatic update(input int b, input int a, input int dlt, output weight_t got);
    set_idle();
    bus.r_addr[b] = AW'(a);
    step();
    set_idle();
    for (int k = 1; k < EC; k++) step();
    bus.w_addr[b] = AW'(a);
    bus.weA[b]    = 1'b1;
    bus.delta[b]  = WIDTH'(dlt);
    step();
    set_idle();
    bus.r_addr[b] = AW'(a);
    step();
    got = bus.w_rd[b];
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_rec_t tbl [9];
    vec_t     exp_v;
    weight_t  got;

    tbl[0] = '{0,  3,  32767, -32767};
    tbl[1] = '{0,  3,      5, -32768};
    tbl[2] = '{0,  3, -32768,      0};
    tbl[3] = '{0,  3, -32765,  32765};
    tbl[4] = '{0,  3,     -5,  32767};
    tbl[5] = '{0,  3, -32768,  32767};
    tbl[6] = '{0,  3,  32767,      0};
    tbl[7] = '{31, 15,    -1,      1};
    tbl[8] = '{4,  7,    -10,     10};

    model_reset();
    set_idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_valid", int'(bus.w_rd_valid), 0);
    reset = 1'b0;

    // Clear sweep length, then every address of every bank reads zero
    wait_ready("clear_len");
    for (int a = 0; a < D; a++) begin
      set_idle();
      bus.cycle_index = CIW'(a);
      for (int i = 0; i < Z; i++) bus.r_addr[i] = AW'(a);
      step();
      chk_vec("idle_zero", bus.w_rd, '0);
    end

    // Two sequential update blocks with delta = 1
    run_block('1, 1);
    for (int a = 0; a < D; a++) begin
      set_idle();
      for (int i = 0; i < Z; i++) bus.r_addr[i] = AW'(a);
      step();
      chk_vec("seq_blk1", bus.w_rd, {Z{16'hFFFF}});
    end
    run_block('1, 1);
    for (int a = 0; a < D; a += 5) begin
      set_idle();
      for (int i = 0; i < Z; i++) bus.r_addr[i] = AW'(a);
      step();
      chk_vec("seq_blk2", bus.w_rd, {Z{16'hFFFE}});
    end

    // Reset mid-RUN with nonzero weights
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    wait_ready("clear_len_rerun");
    for (int c = 0; c < CPC; c++) begin
      set_idle();
      bus.cycle_index = CIW'(c);
      for (int i = 0; i < Z; i++) bus.r_addr[i] = AW'(c % D);
      step();
      chk("valid_gate", int'(bus.w_rd_valid), int'(c < D));
      chk_vec("rerun_zero", bus.w_rd, '0);
    end

    // Partial enable: only bank 0 is written
    set_idle();
    for (int i = 0; i < Z; i++) bus.r_addr[i] = AW'(5);
    step();
    set_idle();
    for (int k = 1; k < EC; k++) step();
    for (int i = 0; i < Z; i++) begin
      bus.w_addr[i] = AW'(5);
      bus.delta[i]  = WIDTH'(2);
    end
    bus.weA = 32'h0000_0001;
    step();
    set_idle();
    for (int i = 0; i < Z; i++) bus.r_addr[i] = AW'(5);
    step();
    exp_v    = '0;
    exp_v[0] = 16'hFFFE;
    chk_vec("partial_en", bus.w_rd, exp_v);

    // Table of single-word updates incl. both saturation limits
    for (int t = 0; t < 9; t++) begin
      update(tbl[t].bank, tbl[t].addr, tbl[t].dlt, got);
      chk("tbl_update", int'(got), tbl[t].exp);
    end

    // Write-first bypass: bank 4 address 7 holds 10, delta 3
    set_idle();
    bus.r_addr[4] = AW'(7);
    step();
    set_idle();
    for (int k = 1; k < EC; k++) step();
    bus.r_addr[4] = AW'(7);
    bus.w_addr[4] = AW'(7);
    bus.weA[4]    = 1'b1;
    bus.delta[4]  = WIDTH'(3);
    step();
    chk("bypass", int'($signed(bus.w_rd[4])), 7);
    set_idle();

    // Random traffic against the model, with one reset in the middle
    for (int k = 0; k < 300; k++) begin
      bus.cycle_index = CIW'(k % CPC);
      bus.weA         = $urandom;
      for (int i = 0; i < Z; i++) begin
        bus.r_addr[i] = AW'($urandom_range(0, D - 1));
        bus.w_addr[i] = AW'($urandom_range(0, D - 1));
        if ($urandom_range(0, 3) == 0) bus.delta[i] = WIDTH'($urandom);
        else bus.delta[i] = WIDTH'(int'($urandom_range(0, 20)) - 10);
      end
      reset = (k == 150 || k == 151);
      step();
    end
    reset = 1'b0;
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
